// File: rtl/circuit2_pkg.sv
// Shared types and constants for the scheduled circuit2 datapath.
package circuit2_pkg;

  localparam int unsigned C2_DATAWIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD1 = 3'd1,
    S_ADD2 = 3'd2,
    S_SUB  = 3'd3,
    S_SEL  = 3'd4,
    S_OUT  = 3'd5,
    S_FIN  = 3'd6
  } state_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational shared adder/subtractor; wraps modulo 2^DATAWIDTH.
module alu_addsub
  import circuit2_pkg::*;
#(
  parameter int unsigned DATAWIDTH = C2_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] op_a,
  input  logic [DATAWIDTH-1:0] op_b,
  input  alu_op_e              op_sel,
  output logic [DATAWIDTH-1:0] res
);

  always_comb begin
    res = '0;
    unique case (op_sel)
      ALU_ADD: res = op_a + op_b;
      ALU_SUB: res = op_a - op_b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/circuit2_sched.sv
// Multi-cycle circuit2 with one shared add/sub unit and start/busy/done handshake.
// Optional `HLS_SIGNED_EN: signed d<e comparison and arithmetic h>>eq.
module circuit2_sched
  import circuit2_pkg::*;
#(
  parameter int unsigned DATAWIDTH = C2_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z,
  output logic                 dLTe,
  output logic                 dEQe
);

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
  logic [DATAWIDTH-1:0] gw_q, gw_d, hw_q, hw_d, xw_q, xw_d;
  logic                 lt_q, lt_d, eq_q, eq_d;

  logic [DATAWIDTH-1:0] g_q, g_d, h_q, h_d, x_q, x_d, z_q, z_d;
  logic                 dlte_q, dlte_d, deqe_q, deqe_d, done_q, done_d;

  logic [DATAWIDTH-1:0] alu_b, alu_res, z_calc;
  logic                 lt_calc;
  alu_op_e              alu_op;

  // Operand mux kept apart from the FSM process to avoid a comb loop through the ALU.
  always_comb begin
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (state_q)
      S_ADD2:  alu_b  = c_q;
      S_SUB:   alu_op = ALU_SUB;
      default: ;
    endcase
  end

  alu_addsub #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .op_a   (a_q),
    .op_b   (alu_b),
    .op_sel (alu_op),
    .res    (alu_res)
  );

`ifdef HLS_SIGNED_EN
  assign lt_calc = $signed(d_q) < $signed(e_q);
  assign z_calc  = $unsigned($signed(hw_q) >>> eq_q);
`else
  assign lt_calc = d_q < e_q;
  assign z_calc  = hw_q >> eq_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d = a_q;  b_d = b_q;  c_d = c_q;
    d_d = d_q;  e_d = e_q;  f_d = f_q;
    gw_d = gw_q;  hw_d = hw_q;  xw_d = xw_q;
    lt_d = lt_q;  eq_d = eq_q;
    g_d = g_q;  h_d = h_q;  x_d = x_q;  z_d = z_q;
    dlte_d = dlte_q;  deqe_d = deqe_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d = a;  b_d = b;  c_d = c;
          state_d = S_ADD1;
        end
      end
      S_ADD1: begin
        d_d = alu_res;
        state_d = S_ADD2;
      end
      S_ADD2: begin
        e_d = alu_res;
        state_d = S_SUB;
      end
      S_SUB: begin
        f_d  = alu_res;
        lt_d = lt_calc;
        eq_d = (d_q == e_q);
        state_d = S_SEL;
      end
      S_SEL: begin
        gw_d = lt_q ? d_q : e_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        hw_d = eq_q ? gw_q : f_q;
        xw_d = gw_q << lt_q;
        state_d = S_FIN;
      end
      S_FIN: begin
        g_d = gw_q;  h_d = hw_q;  x_d = xw_q;  z_d = z_calc;
        dlte_d = lt_q;  deqe_d = eq_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      a_q <= '0;  b_q <= '0;  c_q <= '0;
      d_q <= '0;  e_q <= '0;  f_q <= '0;
      gw_q <= '0;  hw_q <= '0;  xw_q <= '0;
      lt_q <= 1'b0;  eq_q <= 1'b0;
      g_q <= '0;  h_q <= '0;  x_q <= '0;  z_q <= '0;
      dlte_q <= 1'b0;  deqe_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;  b_q <= b_d;  c_q <= c_d;
      d_q <= d_d;  e_q <= e_d;  f_q <= f_d;
      gw_q <= gw_d;  hw_q <= hw_d;  xw_q <= xw_d;
      lt_q <= lt_d;  eq_q <= eq_d;
      g_q <= g_d;  h_q <= h_d;  x_q <= x_d;  z_q <= z_d;
      dlte_q <= dlte_d;  deqe_q <= deqe_d;  done_q <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign g    = g_q;
  assign h    = h_q;
  assign x    = x_q;
  assign z    = z_q;
  assign dLTe = dlte_q;
  assign dEQe = deqe_q;

endmodule

// File: tb/tb_circuit2_sched.sv
// Directed bench for circuit2_sched; expectations follow the HLS_SIGNED_EN build setting.
module tb_circuit2_sched;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        Busy, Done, dLTe, dEQe;
  logic [31:0] g, h, x, z;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;

  always #5 Clk = ~Clk;

  circuit2_sched #(.DATAWIDTH(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .a     (a),
    .b     (b),
    .c     (c),
    .Busy  (Busy),
    .Done  (Done),
    .g     (g),
    .h     (h),
    .x     (x),
    .z     (z),
    .dLTe  (dLTe),
    .dEQe  (dEQe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // From a negedge, count negedges until Done is seen (bounded); -1 on timeout.
  task automatic wait_done(output int cnt);
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] eg, eh, ex, ez,
                           input logic elt, eeq);
    chk({tag, ".g"}, g, eg);
    chk({tag, ".h"}, h, eh);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".z"}, z, ez);
    chk({tag, ".dLTe"}, {31'd0, dLTe}, {31'd0, elt});
    chk({tag, ".dEQe"}, {31'd0, dEQe}, {31'd0, eeq});
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, ib, ic,
                        input logic [31:0] eg, eh, ex, ez, input logic elt, eeq);
    int l;
    a = ia;  b = ib;  c = ic;  Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk({tag, ".busy"}, {31'd0, Busy}, 32'd1);
    wait_done(l);
    chk({tag, ".lat"}, l, 32'd6);
    check_res(tag, eg, eh, ex, ez, elt, eeq);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    chk("rst.done", {31'd0, Done}, 32'd0);
    check_res("rst", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    Rst_n = 1'b1;

    // First edge after reset release accepts Start.
    run_op("v1", 32'd5, 32'd3, 32'd10, 32'd8, 32'd2, 32'd16, 32'd2, 1'b1, 1'b0);
    @(negedge Clk);
    chk("v1.pulse", {31'd0, Done}, 32'd0);
    check_res("v1.hold", 32'd8, 32'd2, 32'd16, 32'd2, 1'b1, 1'b0);

    run_op("v2", 32'd4, 32'd6, 32'd6, 32'd10, 32'd10, 32'd10, 32'd5, 1'b0, 1'b1);

`ifdef HLS_SIGNED_EN
    run_op("v3", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
           32'hFFFFFFFE, 32'd0, 32'hFFFFFFFC, 32'd0, 1'b1, 1'b0);
    run_op("v4", 32'd0, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 1'b1);
`else
    run_op("v3", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
           32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op("v4", 32'd0, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b1);
`endif

    // Start while busy at edge 3, with operands changed mid-flight: ignored.
    a = 32'd5;  b = 32'd3;  c = 32'd10;  Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    a = 32'd4;  b = 32'd6;  c = 32'd6;  Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(lat);
    chk("ign.lat", lat, 32'd3);
    check_res("ign", 32'd8, 32'd2, 32'd16, 32'd2, 1'b1, 1'b0);

    // Start in the Done cycle: next Done exactly 7 cycles later.
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b.pulse", {31'd0, Done}, 32'd0);
    chk("b2b.hold_g", g, 32'd8);
    wait_done(lat);
    chk("b2b.lat", lat, 32'd6);
    check_res("b2b", 32'd10, 32'd10, 32'd10, 32'd5, 1'b0, 1'b1);

    // Reset asserted mid-operation (before edge 4) aborts.
    a = 32'd5;  b = 32'd3;  c = 32'd10;  Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, Busy}, 32'd0);
    chk("abort.done", {31'd0, Done}, 32'd0);
    check_res("abort", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    wait_done(lat);
    chk("abort.nodone", lat, 32'hFFFFFFFF);
    chk("abort.idle", {31'd0, Busy}, 32'd0);

    run_op("post", 32'd5, 32'd3, 32'd10, 32'd8, 32'd2, 32'd16, 32'd2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
